// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky illegal trap.
// Optional performance counters (retired, cycles) are compiled in with `define CTRL_PERF_CNT_EN.
module multicycle_control_fsm #(
   parameter int ALU_OP_W = 4
`ifdef CTRL_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          inst_control,
   input  logic [9:0]          inst_alu,
   input  logic                zero_flag,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic                sel,
   output logic                sel2,
   output logic                regw,
   output logic                alu_src,
   output logic                memw,
   output logic                memr,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    retired,
   output logic [CNT_W-1:0]    cycles
`endif
);

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC    = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_ILLEGAL = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_R   = 3'd0,
      CL_I   = 3'd1,
      CL_LW  = 3'd2,
      CL_SW  = 3'd3,
      CL_BEQ = 3'd4
   } iclass_t;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;

   localparam logic [ALU_OP_W-1:0] OP_AND = ALU_OP_W'(4'b0000);
   localparam logic [ALU_OP_W-1:0] OP_OR  = ALU_OP_W'(4'b0001);
   localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(4'b0010);
   localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(4'b0110);

   state_t                state_r;
   iclass_t               cls_r;
   logic [ALU_OP_W-1:0]   op_r;
   logic                  illegal_r;
   iclass_t               dec_class_s;
   logic [ALU_OP_W-1:0]   dec_op_s;
   logic                  dec_illegal_s;

   // Instruction decoder on the live instruction fields, consumed only in DECODE
   always_comb begin
      dec_class_s   = CL_R;
      dec_op_s      = OP_ADD;
      dec_illegal_s = 1'b0;
      case (inst_control)
         OPC_R: begin
            dec_class_s = CL_R;
            case (inst_alu)
               10'b0000000_000: dec_op_s = OP_ADD;
               10'b0000000_111: dec_op_s = OP_AND;
               10'b0000000_110: dec_op_s = OP_OR;
               10'b0100000_000: dec_op_s = OP_SUB;
               default:         dec_illegal_s = 1'b1;
            endcase
         end
         OPC_I: begin
            dec_class_s = CL_I;
            case (inst_alu[2:0])
               3'b000:  dec_op_s = OP_ADD;
               3'b111:  dec_op_s = OP_AND;
               3'b110:  dec_op_s = OP_OR;
               default: dec_illegal_s = 1'b1;
            endcase
         end
         OPC_LW:  dec_class_s = CL_LW;
         OPC_SW:  dec_class_s = CL_SW;
         OPC_BEQ: begin
            dec_class_s = CL_BEQ;
            dec_op_s    = OP_SUB;
         end
         default: dec_illegal_s = 1'b1;
      endcase
   end

   // State sequencing, decode register and sticky illegal flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_FETCH;
         cls_r     <= CL_R;
         op_r      <= {ALU_OP_W{1'b0}};
         illegal_r <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: state_r <= ST_DECODE;
            ST_DECODE: begin
               cls_r <= dec_class_s;
               op_r  <= dec_op_s;
               if (dec_illegal_s) begin
                  state_r   <= ST_ILLEGAL;
                  illegal_r <= 1'b1;
               end else begin
                  state_r <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (cls_r)
                  CL_R, CL_I:   state_r <= ST_WB;
                  CL_LW, CL_SW: state_r <= ST_MEM;
                  default:      state_r <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  state_r <= (cls_r == CL_LW) ? ST_WB : ST_FETCH;
               end else begin
                  state_r <= ST_MEM;
               end
            end
            ST_WB:      state_r <= ST_FETCH;
            ST_ILLEGAL: state_r <= ST_ILLEGAL;
            default:    state_r <= ST_FETCH;
         endcase
      end
   end

   // Control outputs follow the state and decode register; the async reset of state_r
   // drops memory and register-file strobes without waiting for an edge
   always_comb begin
      pc_en   = 1'b0;
      sel     = 1'b0;
      sel2    = 1'b0;
      regw    = 1'b0;
      alu_src = 1'b0;
      memw    = 1'b0;
      memr    = 1'b0;
      alu_op  = {ALU_OP_W{1'b0}};
      case (state_r)
         ST_EXEC: begin
            alu_op  = op_r;
            alu_src = (cls_r != CL_R) && (cls_r != CL_BEQ);
            if (cls_r == CL_BEQ) begin
               pc_en = 1'b1;
               sel   = zero_flag;
            end else begin
               pc_en = 1'b0;
               sel   = 1'b0;
            end
         end
         ST_MEM: begin
            alu_op  = OP_ADD;
            alu_src = 1'b1;
            memr    = (cls_r == CL_LW);
            memw    = (cls_r == CL_SW);
            pc_en   = mem_ready && (cls_r == CL_SW);
         end
         ST_WB: begin
            alu_op  = op_r;
            alu_src = (cls_r != CL_R);
            regw    = 1'b1;
            sel2    = (cls_r == CL_LW);
            pc_en   = 1'b1;
         end
         default: begin
            pc_en = 1'b0;
         end
      endcase
   end

   assign illegal = illegal_r;

`ifdef CTRL_PERF_CNT_EN
   // Performance counters: cycles freeze once trapped, retired counts PC advances
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycles  <= {CNT_W{1'b0}};
         retired <= {CNT_W{1'b0}};
      end else begin
         if (state_r != ST_ILLEGAL) begin
            cycles <= cycles + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (pc_en) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against a per-instruction timeline model.
module tb_multicycle_control_fsm;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;
   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  inst_control;
   logic [9:0]  inst_alu;
   logic        zero_flag, mem_ready;
   logic        pc_en, sel, sel2, regw, alu_src, memw, memr, illegal;
   logic [3:0]  alu_op;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired, cycles;
`endif
   logic [11:0] ctl_s;

   int checks = 0;
   int errors = 0;
   int exp_cycles = 0;
   int exp_retired = 0;
   logic [11:0] exp_q[$];
   logic        zf_q[$];
   logic        mr_q[$];

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .inst_control(inst_control), .inst_alu(inst_alu),
      .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_en(pc_en), .sel(sel),
      .sel2(sel2), .regw(regw), .alu_src(alu_src), .memw(memw), .memr(memr),
      .alu_op(alu_op), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
      , .retired(retired), .cycles(cycles)
`endif
   );

   always #5 clk = ~clk;
   assign ctl_s = {pc_en, sel, sel2, regw, alu_src, memw, memr, illegal, alu_op};

   function automatic logic [11:0] w12(input logic pc, input logic sl, input logic s2,
                                       input logic rw, input logic src, input logic mw,
                                       input logic mr, input logic il, input logic [3:0] op);
      return {pc, sl, s2, rw, src, mw, mr, il, op};
   endfunction

   function automatic void push(input logic [11:0] e, input logic zf, input logic mr);
      exp_q.push_back(e);
      zf_q.push_back(zf);
      mr_q.push_back(mr);
   endfunction

   // Reference model: expected control words per cycle of one instruction; returns 0 if illegal
   function automatic bit plan(input logic [6:0] opc, input logic [9:0] fa, input int w, input logic zf);
      int kind = 0;
      logic [3:0] op = A_ADD;
      exp_q.delete(); zf_q.delete(); mr_q.delete();
      if (opc == OPC_R) begin
         kind = 1;
         if (fa == 10'h000) op = A_ADD;
         else if (fa == 10'h007) op = A_AND;
         else if (fa == 10'h006) op = A_OR;
         else if (fa == 10'h100) op = A_SUB;
         else kind = 0;
      end else if (opc == OPC_I) begin
         kind = 2;
         if (fa[2:0] == 3'b000) op = A_ADD;
         else if (fa[2:0] == 3'b111) op = A_AND;
         else if (fa[2:0] == 3'b110) op = A_OR;
         else kind = 0;
      end else if (opc == OPC_LW) kind = 3;
      else if (opc == OPC_SW) kind = 4;
      else if (opc == OPC_BEQ) begin kind = 5; op = A_SUB; end
      push(12'h000, 1'($urandom), 1'($urandom));
      push(12'h000, 1'($urandom), 1'($urandom));
      if (kind == 5) begin
         push(w12(1'b1, zf, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op), zf, 1'($urandom));
      end else if (kind == 1 || kind == 2) begin
         push(w12(1'b0, 1'b0, 1'b0, 1'b0, kind == 2, 1'b0, 1'b0, 1'b0, op), 1'($urandom), 1'($urandom));
         push(w12(1'b1, 1'b0, 1'b0, 1'b1, kind == 2, 1'b0, 1'b0, 1'b0, op), 1'($urandom), 1'($urandom));
      end else if (kind == 3 || kind == 4) begin
         push(w12(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD), 1'($urandom), 1'($urandom));
         for (int j = 0; j <= w; j++)
            push(w12(kind == 4 && j == w, 1'b0, 1'b0, 1'b0, 1'b1, kind == 4, kind == 3, 1'b0, A_ADD),
                 1'($urandom), j == w);
         if (kind == 3)
            push(w12(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD), 1'($urandom), 1'($urandom));
      end
      return kind != 0;
   endfunction

   // Drive cycle k of an instruction (inst scrambled after DECODE), then wait for the sample edge
   task automatic drive(input int k, input logic [6:0] opc, input logic [9:0] fa);
      inst_control = (k < 2) ? opc : 7'($urandom);
      inst_alu     = (k < 2) ? fa  : 10'($urandom);
      zero_flag    = zf_q[k];
      mem_ready    = mr_q[k];
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #3;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cycles  = 0;
      exp_retired = 0;
   endtask

   task automatic gen_legal(output logic [6:0] opc, output logic [9:0] fa);
      logic [9:0] r;
      r = 10'($urandom);
      case ($urandom_range(0, 4))
         0: begin
            opc = OPC_R;
            case ($urandom_range(0, 3))
               0: fa = 10'h000;
               1: fa = 10'h007;
               2: fa = 10'h006;
               default: fa = 10'h100;
            endcase
         end
         1: begin
            opc = OPC_I;
            case ($urandom_range(0, 2))
               0: fa = {r[9:3], 3'b000};
               1: fa = {r[9:3], 3'b111};
               default: fa = {r[9:3], 3'b110};
            endcase
         end
         2: begin opc = OPC_LW; fa = r; end
         3: begin opc = OPC_SW; fa = r; end
         default: begin opc = OPC_BEQ; fa = r; end
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inst_control = OPC_LW; inst_alu = 10'h000; zero_flag = 1'b1; mem_ready = 1'b1;
      #12;
      checks++;
      if (ctl_s !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h expected 000", ctl_s); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cycles = 0; exp_retired = 0;
      @(negedge clk);
      checks++;
      if (ctl_s !== 12'h000) begin errors++; $display("FAIL reset_fetch: got %h expected 000", ctl_s); end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (cycles !== 32'd0 || retired !== 32'd0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycles, retired);
      end
`endif
      apply_reset();
   endtask

   task automatic test_alu();
      logic [6:0] opc;
      logic [9:0] fa;
      for (int n = 0; n < 10; n++) begin
         opc = (n < 4 || n[0]) ? OPC_R : OPC_I;
         fa  = (n == 0) ? 10'h000 : (n == 1) ? 10'h007 : (n == 2) ? 10'h006 : (n == 3) ? 10'h100
             : (opc == OPC_R) ? 10'h000 : {7'($urandom), (n[1] ? 3'b111 : 3'b110)};
         void'(plan(opc, fa, 0, 1'b0));
         for (int k = 0; k < exp_q.size(); k++) begin
            drive(k, opc, fa);
            checks++;
            if (ctl_s !== exp_q[k]) begin
               errors++; $display("FAIL alu op=%h fa=%h cyc%0d: got %h expected %h", opc, fa, k, ctl_s, exp_q[k]);
            end
            tick(); exp_cycles++;
         end
         exp_retired++;
      end
   endtask

   task automatic test_mem();
      int w;
      for (int n = 0; n < 8; n++) begin
         w = (n == 0) ? 3 : (n == 1) ? 0 : $urandom_range(0, 4);
         void'(plan(n[0] ? OPC_SW : OPC_LW, 10'($urandom), w, 1'b0));
         for (int k = 0; k < exp_q.size(); k++) begin
            drive(k, n[0] ? OPC_SW : OPC_LW, 10'h000);
            checks++;
            if (ctl_s !== exp_q[k]) begin
               errors++; $display("FAIL mem sw=%0d w=%0d cyc%0d: got %h expected %h", n[0], w, k, ctl_s, exp_q[k]);
            end
            tick(); exp_cycles++;
         end
         exp_retired++;
`ifdef CTRL_PERF_CNT_EN
         checks++;
         if (retired !== 32'(exp_retired) || cycles !== 32'(exp_cycles)) begin
            errors++; $display("FAIL mem_counters: got %0d/%0d expected %0d/%0d", retired, cycles, exp_retired, exp_cycles);
         end
`endif
      end
   endtask

   task automatic test_beq();
      for (int n = 0; n < 6; n++) begin
         void'(plan(OPC_BEQ, 10'($urandom), 0, (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : 1'($urandom)));
         for (int k = 0; k < exp_q.size(); k++) begin
            drive(k, OPC_BEQ, 10'($urandom));
            checks++;
            if (ctl_s !== exp_q[k]) begin
               errors++; $display("FAIL beq cyc%0d: got %h expected %h", k, ctl_s, exp_q[k]);
            end
            tick(); exp_cycles++;
         end
         exp_retired++;
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] opc;
      logic [9:0] fa;
      for (int n = 0; n < 30; n++) begin
         gen_legal(opc, fa);
         void'(plan(opc, fa, $urandom_range(0, 4), 1'($urandom)));
         for (int k = 0; k < exp_q.size(); k++) begin
            drive(k, opc, fa);
            checks++;
            if (ctl_s !== exp_q[k]) begin
               errors++; $display("FAIL b2b op=%h fa=%h cyc%0d: got %h expected %h", opc, fa, k, ctl_s, exp_q[k]);
            end
            tick(); exp_cycles++;
         end
         exp_retired++;
      end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (retired !== 32'(exp_retired) || cycles !== 32'(exp_cycles)) begin
         errors++; $display("FAIL b2b_counters: got %0d/%0d expected %0d/%0d", retired, cycles, exp_retired, exp_cycles);
      end
`endif
   endtask

   task automatic test_illegal();
      logic [6:0] opc;
      logic [9:0] fa;
      for (int n = 0; n < 5; n++) begin
         case (n)
            0: begin opc = 7'b0110111; fa = 10'($urandom); end
            1: begin opc = OPC_R; fa = 10'h101; end
            2: begin opc = OPC_I; fa = {7'($urandom), 3'b001}; end
            3: begin opc = OPC_R; fa = 10'h108; end
            default: begin
               opc = 7'($urandom);
               while (opc == OPC_R || opc == OPC_I || opc == OPC_LW || opc == OPC_SW || opc == OPC_BEQ)
                  opc = 7'($urandom);
               fa = 10'($urandom);
            end
         endcase
         checks++;
         if (plan(opc, fa, 0, 1'b0)) begin errors++; $display("FAIL illegal_model op=%h: got legal expected illegal", opc); end
         for (int k = 0; k < 2; k++) begin
            drive(k, opc, fa);
            checks++;
            if (ctl_s !== exp_q[k]) begin errors++; $display("FAIL illegal_pre cyc%0d: got %h expected %h", k, ctl_s, exp_q[k]); end
            tick(); exp_cycles++;
         end
         for (int k = 0; k < 6; k++) begin
            inst_control = 7'($urandom); inst_alu = 10'($urandom);
            zero_flag = 1'($urandom); mem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (ctl_s !== w12(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0)) begin
               errors++; $display("FAIL illegal_trap op=%h fa=%h cyc%0d: got %h expected 010", opc, fa, k, ctl_s);
            end
            tick();
         end
`ifdef CTRL_PERF_CNT_EN
         checks++;
         if (cycles !== 32'(exp_cycles)) begin errors++; $display("FAIL illegal_cycles_frozen: got %0d expected %0d", cycles, exp_cycles); end
`endif
         reset = 1'b1;
         #1;
         checks++;
         if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_async_clear: got %b expected 0", illegal); end
         apply_reset();
      end
   endtask

   task automatic test_reset_mid_mem();
      void'(plan(OPC_LW, 10'h000, 5, 1'b0));
      for (int k = 0; k < 5; k++) begin
         drive(k, OPC_LW, 10'h000);
         checks++;
         if (ctl_s !== exp_q[k]) begin errors++; $display("FAIL midmem_pre cyc%0d: got %h expected %h", k, ctl_s, exp_q[k]); end
         if (k < 4) begin tick(); exp_cycles++; end
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (memr !== 1'b0 || ctl_s !== 12'h000) begin
         errors++; $display("FAIL midmem_async_drop: got memr=%b ctl=%h expected 0/000", memr, ctl_s);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cycles = 0; exp_retired = 0;
      void'(plan(OPC_R, 10'h000, 0, 1'b0));
      for (int k = 0; k < exp_q.size(); k++) begin
         drive(k, OPC_R, 10'h000);
         checks++;
         if (ctl_s !== exp_q[k]) begin errors++; $display("FAIL midmem_post cyc%0d: got %h expected %h", k, ctl_s, exp_q[k]); end
`ifdef CTRL_PERF_CNT_EN
         checks++;
         if (cycles !== 32'(exp_cycles) || retired !== 32'd0) begin
            errors++; $display("FAIL midmem_counters cyc%0d: got %0d/%0d expected %0d/0", k, cycles, retired, exp_cycles);
         end
`endif
         tick(); exp_cycles++;
      end
      exp_retired++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1);
   end

endmodule
